// File: rtl/conv2_pkg.sv
// Shared constants, types and helpers for the conv2 MAC/accumulate stage.
// Data format is Q8.8 signed; accumulation is carried at full product width.
package conv2_pkg;

  localparam int unsigned TAPS      = 25;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned IN_CH     = 3;
  localparam int unsigned OUT_CH    = 3;
  localparam int unsigned PROD_W    = 2 * DATA_W;
  localparam int unsigned TAP_W     = $clog2(TAPS + 1);

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  localparam acc_t SAT_MAX = acc_t'(32767);

  // Bias aligned to the accumulator's fixed point (Q8.8 * Q8.8 -> 16 fraction bits).
  function automatic acc_t bias_align(input data_t b);
    acc_t ext;
    ext = acc_t'(b);
    return ext <<< FRAC_BITS;
  endfunction

  // Drop the extra fraction bits (floor), clamp negatives to 0, saturate the top.
  function automatic data_t sat_relu(input acc_t full);
    acc_t r;
    r = full >>> FRAC_BITS;
    if (r[ACC_W-1]) begin
      return '0;
    end else if (r > SAT_MAX) begin
      return data_t'(SAT_MAX);
    end else begin
      return data_t'(r);
    end
  endfunction

endpackage

// File: rtl/conv2_dot3.sv
// Combinational 3-term signed dot product of pixels and one output channel's
// weights, with each 32-bit product sign-extended to accumulator width.
// Ports: pixel[3:1], weight[3:1] (Q8.8 signed) -> dot_c (acc_t).
module conv2_dot3
  import conv2_pkg::*;
(
  input  logic signed [DATA_W-1:0] pixel  [IN_CH:1],
  input  logic signed [DATA_W-1:0] weight [IN_CH:1],
  output acc_t                     dot_c
);

  always_comb begin
    logic signed [PROD_W-1:0] prod;
    dot_c = '0;
    prod  = '0;
    for (int i = 1; i <= int'(IN_CH); i++) begin
      prod  = PROD_W'(pixel[i]) * PROD_W'(weight[i]);
      dot_c = dot_c + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv2_mac_accum.sv
// Conv2 compute stage: accumulates 25 taps of a 5x5 kernel for 3 output
// channels, then adds bias, applies ReLU/saturation and hands the result to
// pooling over a valid/ready handshake.
// Ports: clk, reset (sync, active-high); start/ready tap handshake shared with
// the weight supplier; pixel_in, weight_conv2_1..3, bias_conv2 data inputs;
// conv2_out/out_valid/out_ready result handshake; tap_idx debug tap counter.
module conv2_mac_accum
  import conv2_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     ready,
  input  logic signed [DATA_W-1:0] pixel_in       [IN_CH:1],
  input  logic signed [DATA_W-1:0] weight_conv2_1 [IN_CH:1],
  input  logic signed [DATA_W-1:0] weight_conv2_2 [IN_CH:1],
  input  logic signed [DATA_W-1:0] weight_conv2_3 [IN_CH:1],
  input  logic signed [DATA_W-1:0] bias_conv2     [OUT_CH:1],
  output logic signed [DATA_W-1:0] conv2_out      [OUT_CH:1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAP_W-1:0]         tap_idx
);

  state_t state_q, state_d;
  logic   accept_c;
  logic   last_tap_c;
  acc_t   acc_q [OUT_CH:1];
  acc_t   dot_c [OUT_CH:1];
  logic signed [DATA_W-1:0] w_c [OUT_CH:1][IN_CH:1];

  assign w_c[1] = weight_conv2_1;
  assign w_c[2] = weight_conv2_2;
  assign w_c[3] = weight_conv2_3;

  // ready is held low while reset is asserted so the supplier never sees a
  // stale accept in the reset cycle.
  assign ready      = (state_q == ACC) && !reset;
  assign accept_c   = start && ready;
  assign last_tap_c = (tap_idx == TAP_W'(TAPS));

  // One dot product per output channel.
  for (genvar g = 1; g <= int'(OUT_CH); g++) begin : g_dot
    conv2_dot3 u_dot (
      .pixel  (pixel_in),
      .weight (w_c[g]),
      .dot_c  (dot_c[g])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept_c && last_tap_c) state_d = OUT;
      OUT:     if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Tap counter, accumulators and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tap_idx   <= TAP_W'(1);
      out_valid <= 1'b0;
      for (int o = 1; o <= int'(OUT_CH); o++) begin
        acc_q[o]     <= '0;
        conv2_out[o] <= '0;
      end
    end else if (accept_c) begin
      if (last_tap_c) begin
        tap_idx   <= TAP_W'(1);
        out_valid <= 1'b1;
        for (int o = 1; o <= int'(OUT_CH); o++) begin
          conv2_out[o] <= sat_relu(acc_q[o] + dot_c[o] + bias_align(bias_conv2[o]));
          acc_q[o]     <= '0;
        end
      end else begin
        tap_idx <= tap_idx + TAP_W'(1);
        for (int o = 1; o <= int'(OUT_CH); o++) begin
          acc_q[o] <= acc_q[o] + dot_c[o];
        end
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/conv2_mac_accum.md
Name: conv2_mac_accum

Overview:
- Conv2 compute stage, directly downstream of the conv2 weight supplier.
- Each accepted step delivers one tap of a 5x5 kernel:
  - 3 input-channel pixels (pixel_in);
  - 3x3 weights (the supplier's weight_conv2_1/2/3).
- Accumulates 25 taps per window for 3 output channels, then adds bias, applies ReLU and saturates.
- Presents 3 results to the pooling stage with a valid/ready handshake.
- Drives the `ready` input of the weight supplier, so both blocks advance the tap index in lockstep.

Parameters:
- TAPS, 25, taps per window (5x5).
- DATA_W, 16, signed pixel/weight/bias/result width.
- FRAC_BITS, 8, fractional bits of the Q8.8 data format.
- ACC_W, 40, signed accumulator width (32-bit product + 75-term growth, with margin).

Ports:
- clk  in  1  clock; all logic is on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  upstream has a valid tap this cycle; shared with the weight supplier.
- ready  out  1  block can accept a tap; wired to the weight supplier's ready.
- pixel_in  in  3x16 signed [3:1]  input-channel pixels for the current tap.
- weight_conv2_1  in  3x16 signed [3:1]  weights, output channel 1, input channels 1..3.
- weight_conv2_2  in  3x16 signed [3:1]  weights, output channel 2.
- weight_conv2_3  in  3x16 signed [3:1]  weights, output channel 3.
- bias_conv2  in  3x16 signed [3:1]  per-output-channel bias (Q8.8).
- conv2_out  out  3x16 signed [3:1]  ReLU'd, saturated results (Q8.8).
- out_valid  out  1  conv2_out holds a completed window.
- out_ready  in  1  downstream accepts conv2_out.
- tap_idx  out  5  current tap number 1..25 (debug/verification).

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - state=ACC, tap_idx=1, all accumulators=0.
  - conv2_out = all 0, out_valid=0.
  - ready=0 during the reset cycle; ready=1 from the first cycle after reset.
  - The weight supplier must be reset in the same cycle so both tap counts restart at 1.
- Step: a tap is accepted on a posedge where start && ready.
  - Weights are valid only in accepted cycles; they are zero otherwise and must not be relied on.
- Per accepted tap, for each output channel o:
  - acc[o] += sum over i of pixel_in[i]*weight_conv2_o[i].
  - Each product is a full signed 32-bit value; it is sign-extended to ACC_W before summing.
- No accepted step (start=0 in ACC): accumulators and tap_idx hold. Gaps of any length are legal.
- State ACC:
  - ready=1.
  - On an accepted tap with tap_idx<25: tap_idx increments.
  - On an accepted tap with tap_idx==25:
    - full = acc + this tap's products + (bias_conv2[o] sign-extended, << FRAC_BITS).
    - r = full >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
    - ReLU: r<0 becomes 0.
    - Saturate: r>32767 becomes 32767.
    - Register r into conv2_out[o]; set out_valid=1; clear the accumulators; tap_idx=1; go to OUT.
  - Latency: out_valid rises one cycle after the 25th accepted tap.
- State OUT:
  - ready=0, so the weight supplier's count freezes and no taps are accepted.
  - conv2_out and out_valid hold stable until out_ready=1.
  - On out_valid && out_ready: out_valid=0, go to ACC; ready=1 in the next cycle.
  - No back-to-back bypass: each window costs at least one bubble cycle.
- start asserted while ready=0: ignored, no state change.
- Reset mid-window or while in OUT: the partial window is discarded, the pending output is lost, and the reset values apply.
- Wrap-around: tap_idx never exceeds 25 and never reads 0.

Decomposition:
- conv2_pkg holds:
  - constants TAPS, DATA_W, FRAC_BITS, ACC_W, IN_CH=3, OUT_CH=3;
  - typedef data_t (signed [15:0]) and acc_t (signed [ACC_W-1:0]);
  - enum state_t {ACC, OUT};
  - function sat_relu(acc_t) returning data_t.
- One sub-module, conv2_dot3: combinational 3-term signed dot product returning acc_t.
  - Instantiated 3 times, once per output channel.
- Top level holds the FSM, tap counter, accumulators and output registers.

Test Plan:
- Unit case:
  - Stimulus: pixels=256 (1.0), all weights=256, bias=0, start high for 25 cycles, out_ready=1.
  - Response: conv2_out = {19200,19200,19200} (75.0), out_valid one cycle after the 25th tap, ready low during OUT.
- Saturation and ReLU:
  - Stimulus: pixels=512; weight_conv2_1=256, weight_conv2_2=-256, weight_conv2_3=0; bias=0.
  - Response: ch1=32767 (150.0 saturated), ch2=0 (ReLU), ch3=0.
- Bias only:
  - Stimulus: weights=0, bias={128,-128,1000}.
  - Response: conv2_out = {128,0,1000}.
- Gaps and backpressure:
  - Stimulus: unit data with start toggling 1/0 each cycle; out_ready held low 5 cycles after out_valid.
  - Response: result still 19200; conv2_out and out_valid stable for 5 cycles; no tap accepted while ready=0; the next window starts at tap_idx=1.
- Reset mid-window:
  - Stimulus: assert reset after tap 10, then run a full unit window.
  - Response: out_valid=0 after reset, tap_idx=1, final result 19200 (no residue from the aborted window).
- Truncation:
  - Stimulus: pixel ch1=1; weight_conv2_1[1]=-1 on one tap; all other taps zero; bias=0.
  - Response: sum=-1 gives >>>8 = -1, then ReLU gives 0; with weight=+255 and pixel=1, the result is 0 (255>>>8).
